// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/writeback
// and drives the datapath mux selects, write enables, immediate format and ALU operation.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         Op,
  input  logic [2:0]         Funct3,
  input  logic               Funct7b5,
  input  logic               Zero,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ImmSrc,
  output logic [2:0]         ALUControl,
  output logic [STATE_W-1:0] State
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC+4, wait for MemReady
  // DECODE   | OldPC+imm branch target precompute, dispatch on Op
  // MEMADR   | RD1+imm address for lw/sw
  // MEMREAD  | load data read, wait for MemReady
  // MEMWB    | load data -> rd
  // MEMWRITE | single-cycle store strobe
  // EXECUTER | R-type ALU op
  // EXECUTEI | I-type ALU op
  // ALUWB    | ALUOut -> rd
  // BEQ      | compare, PC <- target on Zero
  // JAL      | PC <- target, PC+4 computed for rd
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic [3:0] state_q, state_d, cur_state;
  logic       pc_w, mem_w, ir_w, reg_w;
  logic [1:0] alu_op;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // During reset the outputs present FETCH decode regardless of the held state.
  assign cur_state = rst_n ? state_q : S_FETCH;

  always_comb begin
    state_d   = S_FETCH;
    pc_w      = 1'b0;
    mem_w     = 1'b0;
    ir_w      = 1'b0;
    reg_w     = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = 2'b00;
    case (cur_state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_w      = MemReady;
        pc_w      = MemReady;
        state_d   = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: reg_w = 1'b1;
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        pc_w    = Zero;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_w    = 1'b1;
        state_d = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (Funct3)
          3'b000:  ALUControl = (Op[5] & Funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (Op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  assign PCWrite  = pc_w  & rst_n;
  assign MemWrite = mem_w & rst_n;
  assign IRWrite  = ir_w  & rst_n;
  assign RegWrite = reg_w & rst_n;
  assign State    = STATE_W'(state_q);

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM of the multicycle RV32I core.
- Sits directly upstream of the datapath 4:1 select muxes; its ALUSrcA, ALUSrcB and ResultSrc outputs drive their 2-bit Select inputs.
- Also drives the datapath write enables, the memory address select, the immediate format and the ALU operation.
- Sequences each instruction through fetch/decode/execute/writeback states and waits on a memory-ready handshake.

Parameters:
- STATE_W, 4, width of the state register and of the State debug output (fixed at 4; no other value is legal).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- Op  in  7  instr[6:0] from the instruction register
- Funct3  in  3  instr[14:12]
- Funct7b5  in  1  instr[30]
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory read data valid this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0=PC, 1=Result
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  instruction/OldPC register enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result mux select: 00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  SrcA mux select: 00=PC, 01=OldPC, 10=RD1
- ALUSrcB  out  2  SrcB mux select: 00=RD2, 01=ImmExt, 10=constant 4
- ImmSrc  out  2  immediate format: 00=I, 01=S, 10=B, 11=J
- ALUControl  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt
- State  out  4  current state (debug)

Behaviour:
- One state register updates on the rising clk edge.
- If rst_n=0 at the edge, state <= FETCH (0). Reset takes priority over any transition, including mid-instruction.
- While rst_n=0, PCWrite, MemWrite, IRWrite and RegWrite are forced to 0 combinationally. Other outputs show the FETCH values.
- All outputs are combinational from state, plus Op/Funct3/Funct7b5/Zero/MemReady where noted. No output register.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11-15 are illegal and go to FETCH on the next edge with all enables 0.
- Unlisted outputs are 0 in every state; ALUOp (internal) defaults to 00.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=MemReady; PCWrite=MemReady.
  - MemReady=1 -> DECODE; else stay in FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precompute). Next state by Op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other Op -> FETCH (instruction is a no-op, no writes)
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Op=0000011 -> MEMREAD; otherwise -> MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. MemReady=1 -> MEMWB; else hold.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 for exactly one cycle -> FETCH. Writes do not wait on MemReady.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 -> ALUWB (writes PC+4 to rd).
- ALU decode:
  - ALUOp 00 -> 000; ALUOp 01 -> 001.
  - ALUOp 10, by Funct3:
    - 000 -> 001 if (Op[5] & Funct7b5), else 000
    - 010 -> 101
    - 110 -> 011
    - 111 -> 010
    - any other Funct3 -> 000
- ImmSrc by Op, decoded in every state:
  - 0100011 -> 01
  - 1100011 -> 10
  - 1101111 -> 11
  - else -> 00
- Cycle counts with MemReady tied to 1:
  - lw = 5
  - sw = 4
  - R-type/I-type = 4
  - beq = 3
  - jal = 4
  - illegal Op = 2

Test Plan:
- Reset: assert rst_n=0 while in MEMWRITE -> at the next edge State=0, MemWrite=0; IRWrite and PCWrite stay 0 while rst_n=0.
- lw (Op=0000011), MemReady=1 -> States 0,1,2,3,4,0. In MEMWB: RegWrite=1, ResultSrc=01. In MEMREAD: AdrSrc=1.
- Fetch stall: MemReady=0 for 3 cycles in FETCH -> State held at 0, IRWrite=0, PCWrite=0. The cycle MemReady=1: IRWrite=1, PCWrite=1, then DECODE.
- R-type sub (Op=0110011, Funct3=000, Funct7b5=1) -> EXECUTER shows ALUControl=001, ALUSrcA=10, ALUSrcB=00; ALUWB shows RegWrite=1. addi with Funct7b5=1 (Op=0010011) -> ALUControl=000.
- beq (Op=1100011): Zero=1 -> PCWrite=1 in BEQ, ALUControl=001, ImmSrc=10. Zero=0 -> PCWrite=0. Both cases return to FETCH after 3 cycles.
- jal (Op=1101111) -> States 0,1,10,8,0. In JAL: PCWrite=1, ALUSrcA=01, ALUSrcB=10. ImmSrc=11. Illegal Op=0000000 -> States 0,1,0 with no enables asserted.
